// File: rtl/mips_pkg.sv
// Shared MIPS definitions: loader state encodings and boot-frame geometry.
package mips_pkg;
  localparam logic [2:0] LD_HDR_HI = 3'd0;
  localparam logic [2:0] LD_HDR_LO = 3'd1;
  localparam logic [2:0] LD_DATA   = 3'd2;
  localparam logic [2:0] LD_CSUM   = 3'd3;
  localparam logic [2:0] LD_DONE   = 3'd4;
  localparam logic [2:0] LD_ERR    = 3'd5;

  localparam int LOADER_HDR_BYTES  = 2;
  localparam int LOADER_WORD_BYTES = 4;
endpackage

// File: rtl/mips_loader_packer.sv
// Big-endian byte-to-word packer: word_done_o flags the 4th byte combinationally,
// word_o is the assembled word in that same cycle; stalls cleanly when en_i is low.
module mips_loader_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        res,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);
  localparam logic [1:0] LAST_IDX = 2'(LOADER_WORD_BYTES - 1);

  logic [1:0]  idx_q;
  logic [23:0] shift_q;

  assign word_done_o = en_i && (idx_q == LAST_IDX);
  assign word_o      = {shift_q, byte_i};

  always_ff @(posedge clk) begin
    if (res) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (en_i) begin
      idx_q   <= idx_q + 2'd1;
      shift_q <= {shift_q[15:0], byte_i};
    end
  end
endmodule

// File: rtl/mips_mem_loader.sv
// Boot loader: framed byte stream -> sequential word writes (1 cycle after 4th byte), core held in reset
// until done; in_ready drops only in DONE/ERR. Optional trailing checksum byte via LOADER_CHECKSUM_EN.
module mips_mem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_res,
  output logic              done,
  output logic              err
);
  localparam logic [32:0] CAP = (33'd1 << ADDR_W) - 33'(BASE_ADDR);
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] AFTER_DATA = LD_CSUM;
`else
  localparam logic [2:0] AFTER_DATA = LD_DONE;
`endif

  logic [2:0]        state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       widx_q, widx_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q;
  logic              hs, pk_en, pk_done;
  logic [31:0]       pk_word;
  logic [15:0]       n_full;

  assign in_ready = (state_q == LD_HDR_HI) || (state_q == LD_HDR_LO) ||
                    (state_q == LD_DATA)   || (state_q == LD_CSUM);
  assign hs       = in_valid && in_ready;
  assign pk_en    = hs && (state_q == LD_DATA);
  assign n_full   = {n_q[15:8], in_data};

  mips_loader_packer u_packer (
    .clk         (clk),
    .res         (res),
    .en_i        (pk_en),
    .byte_i      (in_data),
    .word_o      (pk_word),
    .word_done_o (pk_done)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  always_ff @(posedge clk) begin
    if (res)     sum_q <= '0;
    else if (hs) sum_q <= sum_q + in_data;
  end
`endif

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    widx_d   = widx_q;
    mem_we_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      LD_HDR_HI: if (hs) begin
        n_d     = {in_data, 8'h00};
        state_d = LD_HDR_LO;
      end
      LD_HDR_LO: if (hs) begin
        n_d = n_full;
        if (33'(n_full) > CAP)   state_d = LD_ERR;
        else if (n_full == 16'd0) state_d = AFTER_DATA;
        else                      state_d = LD_DATA;
      end
      LD_DATA: if (pk_done) begin
        mem_we_d = 1'b1;
        addr_d   = ADDR_W'(BASE_ADDR) + ADDR_W'(widx_q);
        wdata_d  = pk_word;
        widx_d   = widx_q + 16'd1;
        if (widx_q == n_q - 16'd1) state_d = AFTER_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      LD_CSUM: if (hs) begin
        state_d = (8'(sum_q + in_data) == 8'h00) ? LD_DONE : LD_ERR;
      end
`endif
      default: ;
    endcase
  end

  // done trails entry to DONE by one edge so the final write retires before the core starts.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= LD_HDR_HI;
      n_q      <= '0;
      widx_q   <= '0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      widx_q   <= widx_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_q || (state_q == LD_DONE);
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign cpu_res   = !done_q;
  assign err       = (state_q == LD_ERR);
endmodule

// File: doc/mips_mem_loader.md
# mips_mem_loader

Boot-time program loader for the single-cycle MIPS core. It receives a framed byte stream over a valid/ready interface, packs the bytes into 32-bit words, and writes them sequentially into the core's word-addressed memory. It holds the core in reset until the image is fully written and, optionally, checksum-verified. It is the writer-side counterpart to the end-of-run memory/register dump the bench performs.

## Interface
Parameters:
- ADDR_W, 8, memory word-address width; capacity is 2**ADDR_W words.
- BASE_ADDR, 0, first word address written.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- res  input  1  synchronous, active-high reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle write strobe to memory.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  word to write.
- cpu_res  output  1  reset to the core; high until load completes.
- done  output  1  image loaded successfully; sticky.
- err  output  1  framing or checksum failure; sticky.

## Operation
- Byte transfer occurs on a cycle with in_valid & in_ready.
- Frame: 2-byte word count N (big-endian), then N words of 4 bytes each (big-endian, first byte = bits 31:24), then 1 checksum byte (only if the checksum feature is compiled in).
- States: HDR_HI → HDR_LO → DATA → (CSUM) → DONE. Any state can go → ERR.
- HDR_HI / HDR_LO: capture N.
  - N > 2**ADDR_W - BASE_ADDR → ERR on the HDR_LO handshake.
  - N == 0 → CSUM, or DONE when the checksum feature is absent.
- DATA: 2-bit byte index and word counter. The 4th byte's handshake produces a write on the next cycle:
  - mem_we = 1;
  - mem_addr = BASE_ADDR + word index;
  - mem_wdata = the assembled word.
- After word N-1 is accepted → CSUM (or DONE).
- in_ready = 1 in HDR_HI, HDR_LO, DATA and CSUM. in_ready = 0 in DONE and ERR. Bytes offered in DONE or ERR are ignored.
- DONE: done = 1, cpu_res = 0, mem_we = 0. Held until res.
- ERR: err = 1, cpu_res = 1, in_ready = 0. Held until res.
- Address arithmetic is ADDR_W-bit. The header check guarantees no wrap-around.

## Timing
- Reset values: state HDR_HI, in_ready 1, mem_we 0, mem_addr 0, mem_wdata 0, cpu_res 1, done 0, err 0. Counters, N and the running sum are cleared.
- Write latency: mem_we is high exactly one cycle, the cycle after the 4th byte's handshake. mem_addr and mem_wdata are registered and stable during that cycle.
- done rises, and cpu_res falls, on the same edge, one cycle after the final mem_we pulse (or one cycle after the CSUM byte is accepted). Either way, the last write has completed before the core leaves reset.
- in_valid deasserted mid-word stalls with no side effects; the partial word is retained.
- res mid-load: the next edge returns the block to reset values and discards any partial word. Memory already written is not cleared. A new frame then starts at HDR_HI.
- res has priority over a handshake on the same edge.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The CSUM state exists.
  - Running sum = 8-bit modulo-256 sum of every accepted byte, header included.
  - The checksum byte must make the total sum 0x00, else → ERR.
  - With an error, done never asserts and cpu_res stays 1.
- Not defined: no CSUM state and no sum register. The block goes → DONE directly after the last data word.

## Structure
- Shared package mips_pkg holds:
  - the loader state enumeration (HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR);
  - LOADER_HDR_BYTES = 2 and LOADER_WORD_BYTES = 4.
- One sub-module, mips_loader_packer: shifts bytes in big-endian order and flags word-complete; cleared by res.
- The FSM, counters and checksum live in mips_mem_loader.

## Test plan
- N=3; words 0x20080005, 0x20090007, 0x01095020; valid checksum:
  - mem_we pulses at addresses 0, 1, 2 with those data;
  - done = 1 and cpu_res = 0 one cycle after the last pulse;
  - a later dump shows memory[0..2] equal to those words.
- Same frame with in_valid toggling every other cycle → identical writes and addresses; no extra mem_we pulses.
- N=0x0101 with ADDR_W=8 → err = 1 on the HDR_LO handshake; in_ready = 0; no mem_we; cpu_res stays 1.
- LOADER_CHECKSUM_EN, N=1, word 0x00000001, checksum byte 0x00 (correct is 0xFE) → the write occurs, then err = 1; done = 0; cpu_res = 1.
- res asserted after 2 bytes of word 1 of a 2-word frame:
  - the next edge restores all reset values;
  - word 0 remains in memory;
  - a fresh full frame then loads correctly from address BASE_ADDR.
